// File: rtl/noc_ecc_pkg.sv
// Shared definitions for the NoC SEC-DED core: codeword layout, arbiter
// pointer type and the Hamming(8,4) encode/syndrome helpers.
package noc_ecc_pkg;

    localparam int CW_W = 8;

    // Bit index inside a codeword; Hamming position i+1 lives at bit i.
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D0 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D1 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_P0 = 7;

    typedef enum logic {
        RR_GEN = 1'b0,
        RR_RX  = 1'b1
    } rr_e;

    function automatic logic [CW_W-1:0] ham84_encode(input logic [3:0] nibble);
        logic [CW_W-1:0] cw;
        cw         = '0;
        cw[POS_D0] = nibble[0];
        cw[POS_D1] = nibble[1];
        cw[POS_D2] = nibble[2];
        cw[POS_D3] = nibble[3];
        cw[POS_P1] = nibble[0] ^ nibble[1] ^ nibble[3];
        cw[POS_P2] = nibble[0] ^ nibble[2] ^ nibble[3];
        cw[POS_P4] = nibble[1] ^ nibble[2] ^ nibble[3];
        cw[POS_P0] = ^cw[6:0];
        return cw;
    endfunction

    // Syndrome {c4,c2,c1} over positions 1..7; the value is the erroneous position.
    function automatic logic [2:0] ham84_syndrome(input logic [CW_W-1:0] cw);
        return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    endfunction

endpackage

// File: rtl/noc_ecc_decoder.sv
// Single Hamming(8,4) SEC-DED codeword decoder (purely combinational).
module noc_ecc_decoder
    import noc_ecc_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [3:0]      nibble,
    output logic            corr,
    output logic            uncorr
);

    logic [2:0]      syn;
    logic            par;
    logic [CW_W-1:0] fixed;

    // Correct a single error when overall parity confirms it; a lone P0
    // error leaves the data bits untouched but still counts as corrected.
    always_comb begin
        syn   = ham84_syndrome(cw);
        par   = ^cw;
        fixed = cw;
        if (syn != 3'd0 && par) begin
            fixed[syn - 3'd1] = ~cw[syn - 3'd1];
        end
        nibble = {fixed[POS_D3], fixed[POS_D2], fixed[POS_D1], fixed[POS_D0]};
        corr   = par;
        uncorr = (syn != 3'd0) && !par;
    end

endmodule

// File: rtl/noc_ecc_core.sv
// NoC processing-element core: SEC-DED encode toward the router, decode
// toward the bucket, one shared engine arbitrated round-robin.
module noc_ecc_core
    import noc_ecc_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter int         NIB       = 1,
    parameter logic [1:0] CTRL_CODE = 2'd2,
    parameter int         CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gen_valid,
    output logic                    gen_ready,
    input  logic [ADDR_W+4*NIB-1:0] gen_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ADDR_W+8*NIB-1:0] tx_flit,
    output logic [1:0]              tx_ctrl,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [ADDR_W+8*NIB-1:0] rx_flit,
    output logic                    bkt_valid,
    input  logic                    bkt_ready,
    output logic [ADDR_W+4*NIB-1:0] bkt_data,
    output logic                    bkt_err,
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        uncorr_cnt
);

    localparam int GW = ADDR_W + 4 * NIB;
    localparam int FW = ADDR_W + 8 * NIB;

    rr_e             rr;
    logic            gen_elig, rx_elig, contested;
    logic [FW-1:0]   enc_flit;
    logic [GW-1:0]   dec_data;
    logic [NIB-1:0]  corr_vec, uncorr_vec;
    logic [CNT_W:0]  corr_sum, uncorr_sum;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W:0]   b);
        logic [CNT_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign tx_ctrl = CTRL_CODE;

    // Grant logic: eligibility needs a loadable output register; ties follow rr.
    always_comb begin
        gen_elig  = !rst && gen_valid && (!tx_valid || tx_ready);
        rx_elig   = !rst && rx_valid && (!bkt_valid || bkt_ready);
        contested = gen_elig && rx_elig;
        gen_ready = gen_elig && (!rx_elig || rr == RR_GEN);
        rx_ready  = rx_elig && (!gen_elig || rr == RR_RX);
    end

    // Encoder: address passes through, each nibble becomes one codeword.
    always_comb begin
        enc_flit             = '0;
        enc_flit[ADDR_W-1:0] = gen_data[ADDR_W-1:0];
        for (int k = 0; k < NIB; k++) begin
            enc_flit[ADDR_W + 8*k +: 8] = ham84_encode(gen_data[ADDR_W + 4*k +: 4]);
        end
    end

    assign dec_data[ADDR_W-1:0] = rx_flit[ADDR_W-1:0];

    for (genvar k = 0; k < NIB; k++) begin : g_dec
        noc_ecc_decoder u_dec (
            .cw     (rx_flit[ADDR_W + 8*k +: 8]),
            .nibble (dec_data[ADDR_W + 4*k +: 4]),
            .corr   (corr_vec[k]),
            .uncorr (uncorr_vec[k])
        );
    end

    // Number of affected nibbles in the flit currently offered by the router.
    always_comb begin
        corr_sum   = '0;
        uncorr_sum = '0;
        for (int k = 0; k < NIB; k++) begin
            corr_sum   = corr_sum + {{CNT_W{1'b0}}, corr_vec[k]};
            uncorr_sum = uncorr_sum + {{CNT_W{1'b0}}, uncorr_vec[k]};
        end
    end

    // Output registers, rr pointer and saturating error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid   <= 1'b0;
            tx_flit    <= '0;
            bkt_valid  <= 1'b0;
            bkt_data   <= '0;
            bkt_err    <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            rr         <= RR_GEN;
        end else begin
            if (gen_ready) begin
                tx_valid <= 1'b1;
                tx_flit  <= enc_flit;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            if (rx_ready) begin
                bkt_valid <= 1'b1;
                bkt_data  <= dec_data;
                bkt_err   <= |uncorr_vec;
            end else if (bkt_ready) begin
                bkt_valid <= 1'b0;
            end

            if (contested) begin
                rr <= (rr == RR_GEN) ? RR_RX : RR_GEN;
            end

            if (clr_cnt) begin
                corr_cnt   <= '0;
                uncorr_cnt <= '0;
            end else if (rx_ready) begin
                corr_cnt   <= sat_add(corr_cnt, corr_sum);
                uncorr_cnt <= sat_add(uncorr_cnt, uncorr_sum);
            end
        end
    end

endmodule

// File: tb/tb_noc_ecc_core.sv
// Self-checking bench for noc_ecc_core (ADDR_W=4, NIB=1, CNT_W=8).
module tb_noc_ecc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_valid, gen_ready;
    logic [7:0]  gen_data;
    logic        tx_valid, tx_ready;
    logic [11:0] tx_flit;
    logic [1:0]  tx_ctrl;
    logic        rx_valid, rx_ready;
    logic [11:0] rx_flit;
    logic        bkt_valid, bkt_ready;
    logic [7:0]  bkt_data;
    logic        bkt_err;
    logic        clr_cnt;
    logic [7:0]  corr_cnt, uncorr_cnt;

    noc_ecc_core #(.ADDR_W(4), .NIB(1), .CTRL_CODE(2'd2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .gen_valid  (gen_valid),
        .gen_ready  (gen_ready),
        .gen_data   (gen_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_flit    (tx_flit),
        .tx_ctrl    (tx_ctrl),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_flit    (rx_flit),
        .bkt_valid  (bkt_valid),
        .bkt_ready  (bkt_ready),
        .bkt_data   (bkt_data),
        .bkt_err    (bkt_err),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] flit;
    } gen_vec_t;

    typedef struct {
        logic [11:0] flit;
        logic [7:0]  data;
        logic        err;
        int          corr;
        int          unc;
    } rx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } bkt_exp_t;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [11:0] txq[$];
    bkt_exp_t    bq[$];
    int          grant_log[$];
    logic [11:0] cur_gen_exp;
    rx_vec_t     cur_rx;
    int          exp_corr = 0;
    int          exp_unc  = 0;

    gen_vec_t gv[6];
    rx_vec_t  rv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Scoreboard: expectations pushed at grant, compared at output transfer.
    task automatic monitor();
        bkt_exp_t b;
        logic [11:0] t;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                chk("one_grant", {31'd0, gen_ready && rx_ready}, 32'd0);
                chk("corr_cnt", {24'd0, corr_cnt}, exp_corr);
                chk("uncorr_cnt", {24'd0, uncorr_cnt}, exp_unc);
                if (tx_valid && tx_ready) begin
                    if (txq.size() == 0) fail("tx_unexpected_flit");
                    else begin
                        t = txq.pop_front();
                        chk("tx_flit", {20'd0, tx_flit}, {20'd0, t});
                        chk("tx_ctrl", {30'd0, tx_ctrl}, 32'd2);
                    end
                end
                if (bkt_valid && bkt_ready) begin
                    if (bq.size() == 0) fail("bkt_unexpected_packet");
                    else begin
                        b = bq.pop_front();
                        chk("bkt_data", {24'd0, bkt_data}, {24'd0, b.data});
                        chk("bkt_err", {31'd0, bkt_err}, {31'd0, b.err});
                    end
                end
            end
            if (rst) begin
                txq.delete();
                bq.delete();
                exp_corr = 0;
                exp_unc  = 0;
            end else begin
                if (gen_ready) begin
                    txq.push_back(cur_gen_exp);
                    grant_log.push_back(0);
                end
                if (rx_ready) begin
                    b.data = cur_rx.data;
                    b.err  = cur_rx.err;
                    bq.push_back(b);
                    grant_log.push_back(1);
                end
                if (clr_cnt) begin
                    exp_corr = 0;
                    exp_unc  = 0;
                end else if (rx_ready) begin
                    exp_corr = sat(exp_corr + cur_rx.corr);
                    exp_unc  = sat(exp_unc + cur_rx.unc);
                end
            end
        end
    endtask

    task automatic send_gen(input gen_vec_t v);
        int n;
        gen_data    = v.data;
        cur_gen_exp = v.flit;
        gen_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!gen_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!gen_ready) fail("gen_grant_timeout");
        step();
        gen_valid = 1'b0;
    endtask

    task automatic send_rx(input rx_vec_t v);
        int n;
        rx_flit  = v.flit;
        cur_rx   = v;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) fail("rx_grant_timeout");
        step();
        rx_valid = 1'b0;
    endtask

    task automatic main_seq();
        gv[0] = '{8'hB3, 12'h553};
        gv[1] = '{8'h0A, 12'h00A};
        gv[2] = '{8'hF5, 12'hFF5};
        gv[3] = '{8'h1C, 12'h87C};
        gv[4] = '{8'h80, 12'h4B0};
        gv[5] = '{8'h69, 12'h339};
        rv[0] = '{12'h553, 8'hB3, 1'b0, 0, 0};
        rv[1] = '{12'h453, 8'hB3, 1'b0, 1, 0};
        rv[2] = '{12'hD53, 8'hB3, 1'b0, 1, 0};
        rv[3] = '{12'h563, 8'hB3, 1'b1, 0, 1};
        rv[4] = '{12'h379, 8'h69, 1'b0, 1, 0};
        rv[5] = '{12'hBF5, 8'hF5, 1'b0, 1, 0};
        rv[6] = '{12'h41A, 8'h8A, 1'b1, 0, 1};
        rv[7] = '{12'h87C, 8'h1C, 1'b0, 0, 0};

        rst = 1'b1; clr_cnt = 1'b0;
        gen_valid = 1'b1; gen_data = 8'hB3; rx_valid = 1'b1; rx_flit = 12'h553;
        tx_ready = 1'b1; bkt_ready = 1'b1;
        cur_gen_exp = 12'h553; cur_rx = rv[0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_bkt_valid", {31'd0, bkt_valid}, 32'd0);
        chk("rst_gen_ready", {31'd0, gen_ready}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_flit", {20'd0, tx_flit}, 32'd0);
        chk("rst_bkt_data", {24'd0, bkt_data}, 32'd0);
        chk("rst_bkt_err", {31'd0, bkt_err}, 32'd0);
        chk("rst_corr_cnt", {24'd0, corr_cnt}, 32'd0);
        chk("rst_uncorr_cnt", {24'd0, uncorr_cnt}, 32'd0);
        step();
        rst = 1'b0; gen_valid = 1'b0; rx_valid = 1'b0; mon_en = 1'b1;

        // Encode path: first vector checked for one-cycle latency explicitly.
        send_gen(gv[0]);
        @(negedge clk);
        chk("enc_latency_valid", {31'd0, tx_valid}, 32'd1);
        chk("enc_latency_flit", {20'd0, tx_flit}, 32'h553);
        step();
        for (int i = 1; i < 6; i++) send_gen(gv[i]);

        for (int i = 0; i < 8; i++) send_rx(rv[i]);
        repeat (3) step();

        // Contested arbitration: grants must alternate starting with GEN.
        grant_log.delete();
        gen_data = 8'hB3; cur_gen_exp = 12'h553;
        rx_flit = 12'h553; cur_rx = rv[0];
        gen_valid = 1'b1; rx_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        gen_valid = 1'b0; rx_valid = 1'b0;
        chk("arb_grant_count", grant_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("arb_grant_order", grant_log[i], i % 2);
        repeat (3) step();

        // Backpressure on tx: gen stalls, rx keeps flowing, tx_flit stable.
        tx_ready = 1'b0;
        gen_data = 8'h80; cur_gen_exp = 12'h4B0;
        gen_valid = 1'b1; rx_valid = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_gen_ready", {31'd0, gen_ready}, 32'd0);
            chk("bp_rx_ready", {31'd0, rx_ready}, 32'd1);
            chk("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
            chk("bp_tx_flit", {20'd0, tx_flit}, 32'h4B0);
            step();
        end
        gen_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (3) step();

        // Saturation of the corrected counter, then clear beating an increment.
        rx_flit = 12'h453; cur_rx = rv[1]; rx_valid = 1'b1;
        repeat (262) step();
        rx_valid = 1'b0;
        @(negedge clk);
        chk("sat_corr_cnt", {24'd0, corr_cnt}, 32'd255);
        step();
        rx_valid = 1'b1; clr_cnt = 1'b1;
        step();
        rx_valid = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_beats_inc", {24'd0, corr_cnt}, 32'd0);
        step();

        // Reset with both output registers full.
        tx_ready = 1'b0; bkt_ready = 1'b0;
        gen_data = 8'hB3; cur_gen_exp = 12'h553; gen_valid = 1'b1;
        rx_flit = 12'h453; cur_rx = rv[1]; rx_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("pre_rst_tx_full", {31'd0, tx_valid}, 32'd1);
        chk("pre_rst_bkt_full", {31'd0, bkt_valid}, 32'd1);
        chk("pre_rst_corr_cnt", {24'd0, corr_cnt}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_gen_ready", {31'd0, gen_ready}, 32'd0);
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("post_rst_bkt_valid", {31'd0, bkt_valid}, 32'd0);
        chk("post_rst_corr_cnt", {24'd0, corr_cnt}, 32'd0);
        chk("post_rst_uncorr_cnt", {24'd0, uncorr_cnt}, 32'd0);
        chk("post_rst_first_gen", {31'd0, gen_ready}, 32'd1);
        chk("post_rst_first_rx", {31'd0, rx_ready}, 32'd0);
        step();
        tx_ready = 1'b1; bkt_ready = 1'b1;
        repeat (4) step();
        gen_valid = 1'b0; rx_valid = 1'b0;
        repeat (5) step();
        chk("drain_txq", txq.size(), 32'd0);
        chk("drain_bq", bq.size(), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            main_seq();
            begin
                #200000;
                fail("watchdog_timeout");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_ecc_core.md
Name: noc_ecc_core

Overview:
- Clocked, parametrised successor of the async NoC processing-element core.
- Generator path: encodes local packets into SEC-DED Hamming flits for the router. Router path: decodes received flits, corrects single-bit errors, flags double-bit errors and delivers to the bucket.
- A single shared engine is arbitrated round-robin between the two paths.
- Saturating error counters are exported for monitoring.

Parameters:
- ADDR_W, 4, destination/IP field width in bits.
- NIB, 1, number of 4-bit data nibbles per packet; each nibble becomes one 8-bit Hamming(8,4) SEC-DED codeword.
- CTRL_CODE, 2, value driven on tx_ctrl with every flit.
- CNT_W, 8, width of the error counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- gen_valid  in  1  generator packet valid.
- gen_ready  out  1  generator packet accepted this cycle.
- gen_data  in  ADDR_W+4*NIB  {nibbles, addr}.
- tx_valid  out  1  flit to router valid.
- tx_ready  in  1  router accepts flit.
- tx_flit  out  ADDR_W+8*NIB  {codewords, addr}.
- tx_ctrl  out  2  CTRL_CODE, qualified by tx_valid.
- rx_valid  in  1  router flit valid.
- rx_ready  out  1  router flit accepted this cycle.
- rx_flit  in  ADDR_W+8*NIB  received flit.
- bkt_valid  out  1  decoded packet valid.
- bkt_ready  in  1  bucket accepts packet.
- bkt_data  out  ADDR_W+4*NIB  {corrected nibbles, addr}.
- bkt_err  out  1  1 = at least one nibble was uncorrectable.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  corrected-codeword count, saturating.
- uncorr_cnt  out  CNT_W  uncorrectable-codeword count, saturating.

Behaviour:
- Handshake: valid/ready. Transfer occurs on a rising edge with valid && ready. Valid, once high, holds with stable data until the transfer.
- Reset (rst=1 at an edge):
  - tx_valid=0, bkt_valid=0, tx_flit=0, bkt_data=0, bkt_err=0.
  - corr_cnt=0, uncorr_cnt=0, rr pointer=GEN.
  - Any flit or packet held in an output register is discarded.
  - gen_ready and rx_ready are 0 while rst=1.
- Output registers: tx and bkt each have a 1-entry register. A register "can load" if it is empty, or its consumer's ready is high this cycle.
- Arbitration (combinational):
  - A requester is eligible if its valid is high and its output register can load.
  - Only one eligible requester: it is granted.
  - Both eligible: grant follows the rr pointer (GEN or RX). The pointer toggles only after such a contested grant.
  - gen_ready = grant_gen; rx_ready = grant_rx. At most one is high per cycle.
- Latency: a packet accepted at edge N appears on its output after edge N (1 cycle). Sustained throughput is 1 transfer/cycle total.
- Codeword layout (nibble k at bits [ADDR_W+8k +: 8]):
  - cw[i] holds Hamming position i+1 for i=0..6; cw[7] is overall parity P0.
  - Positions: 1=P1, 2=P2, 3=D0, 4=P4, 5=D1, 6=D2, 7=D3, where nibble bit j = Dj.
  - P1=D0^D1^D3, P2=D0^D2^D3, P4=D1^D2^D3, P0=XOR of cw[6:0].
- Address handling: the address field passes through unchanged in both directions.
- Decode, per nibble: syndrome s={c4,c2,c1} over positions 1..7; p = XOR of all 8 bits.
  - s=0, p=0: clean.
  - s≠0, p=1: flip position s; counts as corrected.
  - s=0, p=1: P0 error only; data good; counts as corrected.
  - s≠0, p=0: double error; data passed uncorrected; sets bkt_err; counts as uncorrectable.
- Counters:
  - Add the number of affected nibbles of the accepted rx flit, in the cycle of acceptance.
  - Saturate at 2^CNT_W-1.
  - clr_cnt has priority over increment in the same cycle; rst has priority over all.

Decomposition:
- Package noc_ecc_pkg holds:
  - codeword width constant CW_W=8;
  - position indices;
  - rr pointer enum {RR_GEN, RR_RX};
  - pure functions ham84_encode(nibble) and ham84_syndrome(cw).
- Sub-module noc_ecc_decoder (one codeword) returns corrected nibble, corr flag and uncorr flag. It is instantiated NIB times via generate.
- The encoder stays inline using the package function.

Test Plan:
- Encode: ADDR_W=4, NIB=1, gen_data=8'hB3, tx_ready=1 -> next cycle tx_flit=12'h553, tx_ctrl=2, tx_valid=1.
- Clean and single-error receive:
  - rx_flit=12'h553 -> bkt_data=8'hB3, bkt_err=0, counters unchanged.
  - rx_flit=12'h453 (pos5 flipped) -> bkt_data=8'hB3, bkt_err=0, corr_cnt=1.
  - rx_flit=12'hD53 (P0 flipped) -> bkt_data=8'hB3, corr_cnt+1.
- Double error: rx_flit=12'h563 -> bkt_data=8'hB3, bkt_err=1, uncorr_cnt=1.
- Arbitration: gen_valid and rx_valid held high, both readies high, for 6 cycles -> grants alternate GEN,RX,GEN,RX,GEN,RX; never both ready high in one cycle.
- Backpressure and boundary:
  - tx_ready=0 with tx register full -> gen_ready=0 and rx traffic keeps flowing; tx_flit stays stable.
  - 255+ corrections with CNT_W=8 -> corr_cnt stays 255.
  - clr_cnt together with a correction -> counter 0.
- Reset mid-operation: assert rst with both output registers full -> next cycle tx_valid=bkt_valid=0, counters=0. The first contested grant after reset goes to GEN.
